// File: rtl/mem_copy_engine_pkg.sv
// Shared widths, memory port selector codes and FSM state type for the copy engine.
package mem_copy_engine_pkg;

    localparam int unsigned MEMORY_ADDR_WIDTH = 8;
    localparam int unsigned WORD_WIDTH        = 16;

    localparam logic MEMORY_READ  = 1'b0;
    localparam logic MEMORY_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic state_is_busy(input state_e s);
        return (s == ST_READ) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/mem_copy_engine_if.sv
// Command/status and single-port memory bus of the copy engine.
interface mem_copy_engine_if
    import mem_copy_engine_pkg::*;
#(
    parameter int unsigned ADDR_W = MEMORY_ADDR_WIDTH,
    parameter int unsigned WORD_W = WORD_WIDTH
);
    logic              start;
    logic              fill_mode;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W:0]   length;
    logic [WORD_W-1:0] fill_value;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [ADDR_W:0]   words_done;
    logic [ADDR_W-1:0] mem_address;
    logic [WORD_W-1:0] mem_data_write;
    logic              mem_read_write_selector;
    logic [WORD_W-1:0] mem_data_read;

    modport slave (
        input  start, fill_mode, src_addr, dst_addr, length, fill_value, abort,
        input  mem_data_read,
        output busy, done, aborted, words_done,
        output mem_address, mem_data_write, mem_read_write_selector
    );

    modport master (
        output start, fill_mode, src_addr, dst_addr, length, fill_value, abort,
        output mem_data_read,
        input  busy, done, aborted, words_done,
        input  mem_address, mem_data_write, mem_read_write_selector
    );
endinterface

// File: rtl/mem_copy_engine_counter.sv
// Source/destination address pointers and written-word counter for the copy engine.
module mem_copy_engine_counter
    import mem_copy_engine_pkg::*;
#(
    parameter int unsigned ADDR_W = MEMORY_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [ADDR_W:0]   len_in,
    output logic [ADDR_W-1:0] src_q,
    output logic [ADDR_W-1:0] dst_q,
    output logic [ADDR_W-1:0] src_inc,
    output logic [ADDR_W-1:0] dst_inc,
    output logic [ADDR_W:0]   words_q,
    output logic              last
);
    logic [ADDR_W-1:0] src_d;
    logic [ADDR_W-1:0] dst_d;
    logic [ADDR_W:0]   words_d;
    logic [ADDR_W:0]   words_inc;
    logic [ADDR_W:0]   len_d;
    logic [ADDR_W:0]   len_q;

    always_comb begin
        // Pointers wrap naturally at 2^ADDR_W.
        src_inc   = src_q + ADDR_W'(1);
        dst_inc   = dst_q + ADDR_W'(1);
        words_inc = words_q + (ADDR_W+1)'(1);
        last      = (words_inc == len_q);

        src_d   = src_q;
        dst_d   = dst_q;
        words_d = words_q;
        len_d   = len_q;
        if (load) begin
            src_d   = src_in;
            dst_d   = dst_in;
            words_d = '0;
            len_d   = len_in;
        end else if (step) begin
            src_d   = src_inc;
            dst_d   = dst_inc;
            words_d = words_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            src_q   <= '0;
            dst_q   <= '0;
            words_q <= '0;
            len_q   <= '0;
        end else begin
            src_q   <= src_d;
            dst_q   <= dst_d;
            words_q <= words_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: rtl/mem_copy_engine.sv
// Word-at-a-time memory copy / fill engine driving a single-port memory with
// combinational read data; all outputs are registered.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int unsigned ADDR_W = MEMORY_ADDR_WIDTH,
    parameter int unsigned WORD_W = WORD_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    mem_copy_engine_if.slave   bus
);
    state_e            state_d, state_q;
    logic              mode_d, mode_q;
    logic [WORD_W-1:0] fill_d, fill_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic              aborted_d, aborted_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [WORD_W-1:0] wdata_d, wdata_q;
    logic              sel_d, sel_q;

    logic              cnt_load;
    logic              cnt_step;
    logic [ADDR_W-1:0] src_q, dst_q, src_inc, dst_inc;
    logic [ADDR_W:0]   words_q;
    logic              cnt_last;

    mem_copy_engine_counter #(.ADDR_W(ADDR_W)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .step    (cnt_step),
        .src_in  (bus.src_addr),
        .dst_in  (bus.dst_addr),
        .len_in  (bus.length),
        .src_q   (src_q),
        .dst_q   (dst_q),
        .src_inc (src_inc),
        .dst_inc (dst_inc),
        .words_q (words_q),
        .last    (cnt_last)
    );

    // Outputs are decoded from the next state so that they are registered yet
    // line up with the state they belong to; the write-data register doubles
    // as the captured read word.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        fill_d    = fill_q;
        aborted_d = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;
        sel_d     = MEMORY_READ;
        cnt_load  = 1'b0;
        cnt_step  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    cnt_load = 1'b1;
                    mode_d   = bus.fill_mode;
                    fill_d   = bus.fill_value;
                    if (bus.length == '0) begin
                        state_d = ST_DONE;
                    end else if (bus.fill_mode) begin
                        state_d = ST_WRITE;
                        addr_d  = bus.dst_addr;
                        wdata_d = bus.fill_value;
                        sel_d   = MEMORY_WRITE;
                    end else begin
                        state_d = ST_READ;
                        addr_d  = bus.src_addr;
                    end
                end
            end
            ST_READ: begin
                if (bus.abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                    addr_d  = dst_q;
                    wdata_d = bus.mem_data_read;
                    sel_d   = MEMORY_WRITE;
                end
            end
            ST_WRITE: begin
                cnt_step = 1'b1;
                if (bus.abort || cnt_last) begin
                    state_d   = ST_DONE;
                    aborted_d = bus.abort && !cnt_last;
                end else if (mode_q) begin
                    addr_d  = dst_inc;
                    wdata_d = fill_q;
                    sel_d   = MEMORY_WRITE;
                end else begin
                    state_d = ST_READ;
                    addr_d  = src_inc;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = state_is_busy(state_d);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            fill_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= MEMORY_READ;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            fill_q    <= fill_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sel_q     <= sel_d;
        end
    end

    assign bus.busy                    = busy_q;
    assign bus.done                    = done_q;
    assign bus.aborted                 = aborted_q;
    assign bus.words_done              = words_q;
    assign bus.mem_address             = addr_q;
    assign bus.mem_data_write          = wdata_q;
    assign bus.mem_read_write_selector = sel_q;

endmodule
